// File: rtl/sig_verifier.sv
// sig_verifier: LDGM signature verifier.
// On a rising edge of start it recomputes the syndrome H*s over GF(2), one
// column per clock, from the constant signature SIG_INIT. Column j of H is
// H_SEED rotated left by (j mod R). The result passes when the syndrome
// equals SYND_INIT and the weight of s is at most W_MAX.
// Optional build macro: SIGVERIFY_EARLY_ABORT_EN. When it is defined, the
// column scan stops as soon as the weight exceeds W_MAX. The result is the
// same; only the latency is shorter.
module sig_verifier #(
  parameter int              N         = 64,
  parameter int              R         = 32,
  parameter int              W_MAX     = 8,
  parameter logic [R-1:0]    H_SEED    = 32'h0000_0001,
  parameter logic [N-1:0]    SIG_INIT  = 64'h0000_0000_0000_000F,
  parameter logic [R-1:0]    SYND_INIT = 32'h0000_000F
) (
  input  logic clk,
  input  logic rst_b,
  input  logic start,
  output logic sigvalid,
  output logic finish
);

  localparam int WT_W  = $clog2(N + 1);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    CHECK   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              start_d;
  logic              trigger;
  logic [R-1:0]      acc;
  logic [WT_W-1:0]   wt;
  logic [IDX_W-1:0]  idx;
  logic              cur_bit;
  logic              clear_run;
  logic              step_col;
  logic              do_check;

  // Column j of H: the seed rotated left by (j mod R), built from a doubled copy
  function automatic logic [R-1:0] col_of(input logic [IDX_W-1:0] j);
    logic [2*R-1:0] dbl;
    int             sh;
    sh  = int'(j) % R;
    dbl = {H_SEED, H_SEED} << sh;
    return dbl[2*R-1:R];
  endfunction

  assign trigger = start && !start_d;
  assign cur_bit = SIG_INIT[idx];

  // State register; reset drops any run in progress back to IDLE
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; triggers are only honoured in IDLE and DONE
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (trigger) state_next = COMPUTE;
      end
      COMPUTE: begin
        if (idx == IDX_W'(N - 1)) state_next = CHECK;
`ifdef SIGVERIFY_EARLY_ABORT_EN
        if (cur_bit && (int'(wt) >= W_MAX)) state_next = CHECK;
`endif
      end
      CHECK: begin
        state_next = DONE;
      end
      DONE: begin
        if (trigger) state_next = COMPUTE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath controls decoded from the current state
  always_comb begin
    clear_run = trigger && ((state == IDLE) || (state == DONE));
    step_col  = (state == COMPUTE);
    do_check  = (state == CHECK);
  end

  // Edge detector, column accumulator, weight counter and result registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      start_d  <= 1'b0;
      acc      <= '0;
      wt       <= '0;
      idx      <= '0;
      finish   <= 1'b0;
      sigvalid <= 1'b0;
    end else begin
      start_d <= start;
      if (clear_run) begin
        acc      <= '0;
        wt       <= '0;
        idx      <= '0;
        finish   <= 1'b0;
        sigvalid <= 1'b0;
      end else if (step_col) begin
        if (cur_bit) begin
          acc <= acc ^ col_of(idx);
          wt  <= wt + 1'b1;
        end
        idx <= idx + 1'b1;
      end else if (do_check) begin
        sigvalid <= (acc == SYND_INIT) && (int'(wt) <= W_MAX);
        finish   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sig_verifier.sv
// tb_sig_verifier: directed bench for sig_verifier.
// Seven instances with different constant operands share one clock, reset
// and start. Every instance has its own expected result and latency. The
// trigger edge counts as edge 1, so a full run shows finish at edge 66.
module tb_sig_verifier;

  localparam int NUM = 7;

`ifdef SIGVERIFY_EARLY_ABORT_EN
  localparam int HEAVY_EDGE = 11;
`else
  localparam int HEAVY_EDGE = 66;
`endif

  typedef struct {
    int    unit;
    bit    expSig;
    int    expEdge;
    string name;
  } vec_t;

  logic           clk;
  logic           rst_b;
  logic           start;
  logic [NUM-1:0] finishV;
  logic [NUM-1:0] sigvalidV;

  vec_t           vecs[NUM];
  int             firstEdge[NUM];
  bit             sigAtFinish[NUM];
  logic [NUM-1:0] edge1Finish;
  logic [NUM-1:0] edge1Sig;
  logic [NUM-1:0] expSigVec;
  int             tests;
  int             failures;

  // Default operands: s = 0xF, H = identity-like, expected 0xF -> pass
  sig_verifier u_default (
    .clk(clk), .rst_b(rst_b), .start(start),
    .sigvalid(sigvalidV[0]), .finish(finishV[0])
  );

  // Upper columns 32..35 wrap onto syndrome bits 0..3 -> pass
  sig_verifier #(.SIG_INIT(64'h0000_000F_0000_0000), .SYND_INIT(32'h0000_000F)) u_upper (
    .clk(clk), .rst_b(rst_b), .start(start),
    .sigvalid(sigvalidV[1]), .finish(finishV[1])
  );

  // Syndrome mismatch -> fail
  sig_verifier #(.SYND_INIT(32'h0000_0007)) u_mismatch (
    .clk(clk), .rst_b(rst_b), .start(start),
    .sigvalid(sigvalidV[2]), .finish(finishV[2])
  );

  // Syndrome matches but weight 16 -> fail
  sig_verifier #(.SIG_INIT(64'h0000_0000_0000_FFFF), .SYND_INIT(32'h0000_FFFF)) u_heavy (
    .clk(clk), .rst_b(rst_b), .start(start),
    .sigvalid(sigvalidV[3]), .finish(finishV[3])
  );

  // Seed 0x3, s bits {0,5,31,40}: 0x3 ^ 0x60 ^ 0x80000001 ^ 0x300 = 0x80000362 -> pass
  sig_verifier #(.H_SEED(32'h0000_0003), .SIG_INIT(64'h0000_0100_8000_0021),
                 .SYND_INIT(32'h8000_0362)) u_seed3 (
    .clk(clk), .rst_b(rst_b), .start(start),
    .sigvalid(sigvalidV[4]), .finish(finishV[4])
  );

  // Weight exactly W_MAX = 8 -> pass
  sig_verifier #(.SIG_INIT(64'h0000_0000_0000_00FF), .SYND_INIT(32'h0000_00FF)) u_w8 (
    .clk(clk), .rst_b(rst_b), .start(start),
    .sigvalid(sigvalidV[5]), .finish(finishV[5])
  );

  // Weight 9, one over the limit -> fail
  sig_verifier #(.SIG_INIT(64'h0000_0000_0000_01FF), .SYND_INIT(32'h0000_01FF)) u_w9 (
    .clk(clk), .rst_b(rst_b), .start(start),
    .sigvalid(sigvalidV[6]), .finish(finishV[6])
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and report a failure in a single line
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Raise start on a falling edge, optionally releasing reset at the same time.
  // Then watch 70 edges and record where each instance first shows finish.
  task automatic applyStimulus(input bit releaseReset);
    for (int k = 0; k < NUM; k++) begin
      firstEdge[k]   = 0;
      sigAtFinish[k] = 1'b0;
    end
    @(negedge clk);
    start = 1'b1;
    if (releaseReset) rst_b = 1'b1;
    for (int e = 1; e <= 70; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) begin
        edge1Finish = finishV;
        edge1Sig    = sigvalidV;
      end
      for (int k = 0; k < NUM; k++) begin
        if ((firstEdge[k] == 0) && (finishV[k] === 1'b1)) begin
          firstEdge[k]   = e;
          sigAtFinish[k] = sigvalidV[k];
        end
      end
    end
  endtask

  // Compare the recorded latency and result of every instance with the table
  task automatic checkTable(input string phase);
    for (int i = 0; i < NUM; i++) begin
      checkOutput($sformatf("%s %s finish edge", phase, vecs[i].name),
                  firstEdge[vecs[i].unit], vecs[i].expEdge);
      checkOutput($sformatf("%s %s sigvalid at finish", phase, vecs[i].name),
                  {31'b0, sigAtFinish[vecs[i].unit]}, {31'b0, vecs[i].expSig});
      checkOutput($sformatf("%s %s sigvalid held", phase, vecs[i].name),
                  {31'b0, sigvalidV[vecs[i].unit]}, {31'b0, vecs[i].expSig});
    end
  endtask

  // Main sequence
  initial begin
    tests    = 0;
    failures = 0;
    vecs[0] = '{unit: 0, expSig: 1'b1, expEdge: 66,         name: "default"};
    vecs[1] = '{unit: 1, expSig: 1'b1, expEdge: 66,         name: "upper_cols"};
    vecs[2] = '{unit: 2, expSig: 1'b0, expEdge: 66,         name: "synd_mismatch"};
    vecs[3] = '{unit: 3, expSig: 1'b0, expEdge: HEAVY_EDGE, name: "weight16"};
    vecs[4] = '{unit: 4, expSig: 1'b1, expEdge: 66,         name: "seed3_rotate"};
    vecs[5] = '{unit: 5, expSig: 1'b1, expEdge: 66,         name: "weight8"};
    vecs[6] = '{unit: 6, expSig: 1'b0, expEdge: HEAVY_EDGE, name: "weight9"};
    expSigVec = '0;
    for (int i = 0; i < NUM; i++) expSigVec[vecs[i].unit] = vecs[i].expSig;

    rst_b = 1'b0;
    start = 1'b0;
    #100;
    checkOutput("reset finish", {25'b0, finishV}, 32'h0);
    checkOutput("reset sigvalid", {25'b0, sigvalidV}, 32'h0);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("idle no spontaneous run", {25'b0, finishV}, 32'h0);

    applyStimulus(1'b0);
    checkOutput("first run edge1 finish", {25'b0, edge1Finish}, 32'h0);
    checkTable("run1");

    repeat (20) @(posedge clk);
    #1;
    checkOutput("start held no retrigger finish", {25'b0, finishV}, 32'h7F);
    checkOutput("start held no retrigger sigvalid", {25'b0, sigvalidV}, {25'b0, expSigVec});

    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("start low keeps result", {25'b0, finishV}, 32'h7F);
    applyStimulus(1'b0);
    checkOutput("retrigger clears finish", {25'b0, edge1Finish}, 32'h0);
    checkOutput("retrigger clears sigvalid", {25'b0, edge1Sig}, 32'h0);
    checkTable("run2");

    @(negedge clk);
    #2;
    rst_b = 1'b0;
    start = 1'b0;
    #1;
    checkOutput("reset in DONE finish", {25'b0, finishV}, 32'h0);
    checkOutput("reset in DONE sigvalid", {25'b0, sigvalidV}, 32'h0);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("after reset no run", {25'b0, finishV}, 32'h0);

    @(negedge clk);
    start = 1'b1;
    repeat (21) @(posedge clk);
    #2;
    rst_b = 1'b0;
    start = 1'b0;
    #1;
    checkOutput("mid-run reset finish", {25'b0, finishV}, 32'h0);
    checkOutput("mid-run reset sigvalid", {25'b0, sigvalidV}, 32'h0);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("aborted run stays idle", {25'b0, finishV}, 32'h0);
    applyStimulus(1'b0);
    checkTable("after abort");

    @(negedge clk);
    #2;
    rst_b = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    applyStimulus(1'b1);
    checkTable("start high at release");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/sig_verifier.md
Name: sig_verifier

Overview:
- Self-contained LDGM signature verifier. On a start request it recomputes the syndrome H*s over GF(2) from an internal signature vector s and the parity-check matrix H.
- It compares the result with a stored expected syndrome and checks that the Hamming weight of s does not exceed W_MAX.
- It reports a pass/fail flag with a completion strobe. All operands are parameter/ROM constants; the top-level control is the only external interface.

Parameters:
- N, 64, code length (signature bits, columns of H).
- R, 32, syndrome length (rows of H), R <= N.
- W_MAX, 8, maximum legal signature weight (inclusive).
- H_SEED, 32'h0000_0001, R-bit seed; column j of H = H_SEED rotated left by (j mod R).
- SIG_INIT, 64'h0000_0000_0000_000F, N-bit signature s.
- SYND_INIT, 32'h0000_000F, R-bit expected syndrome.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_b  input  1  reset, asynchronous, active-low.
- start  input  1  start request; level signal, rising edge triggers a run.
- sigvalid  output  1  verification result; meaningful only while finish=1.
- finish  output  1  high while a result is held.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_b is asynchronous, active-low.
- Reset values: state=IDLE, finish=0, sigvalid=0, accumulator=0, weight=0, column index=0, start_d=0.
- Start edge detection: start_d registers start every cycle. A trigger is start=1 && start_d=0 sampled at a rising edge. A level held high does not retrigger.
- States: IDLE, COMPUTE, CHECK, DONE.
- IDLE, on trigger:
  - acc<=0, wt<=0, idx<=0.
  - finish<=0, sigvalid<=0.
  - go to COMPUTE.
- COMPUTE, one column per clock:
  - if s[idx]=1: acc<=acc^col(idx) and wt<=wt+1.
  - idx<=idx+1.
  - after processing idx=N-1, go to CHECK.
  - exactly N cycles in COMPUTE.
- CHECK (one cycle):
  - sigvalid<=(acc==SYND_INIT)&&(wt<=W_MAX).
  - finish<=1.
  - go to DONE.
- DONE:
  - hold finish=1 and sigvalid.
  - a new trigger clears both and restarts as from IDLE.
- Latency: finish rises N+2 rising edges after the edge that samples the trigger. Default: 66 edges.
- Triggers in COMPUTE or CHECK are ignored (start_d still tracks start).
- rst_b low mid-run aborts immediately to reset values. A run needs a fresh rising edge of start after reset release; a start already high at release counts as a rising edge because start_d=0.
- Widths:
  - wt is ceil(log2(N+1)) bits and never wraps, since it counts at most N.
  - idx is ceil(log2(N)) bits; its wrap at N is not used because COMPUTE exits first.
- col(j): combinational rotate of H_SEED. No RAM is required.

Optional Feature:
- Macro: SIGVERIFY_EARLY_ABORT_EN.
- Defined: in COMPUTE, if an increment would make wt exceed W_MAX, go directly to CHECK on that edge. CHECK then yields sigvalid=0, so latency is shortened.
- Undefined: always N COMPUTE cycles, fixed latency N+2.
- Results (sigvalid) are identical either way; only latency differs.

Test Plan:
- Defaults, rst_b low 100 ns, release, start high 10 cycles:
  - finish=1, sigvalid=1 at edge 66 after the trigger.
  - finish stays 1 while start is held, no retrigger.
- SIG_INIT=64'h0000_000F_0000_0000, SYND_INIT=32'h0000_000F:
  - acc = 0x0000000F (cols 32..35 map to bits 0..3), wt=4, so sigvalid=1.
- SYND_INIT=32'h0000_0007 with default s:
  - finish=1, sigvalid=0 (syndrome mismatch).
- SIG_INIT=64'h0000_0000_0000_FFFF, SYND_INIT=32'h0000_FFFF, W_MAX=8:
  - syndrome matches but wt=16 > 8, so sigvalid=0.
  - with SIGVERIFY_EARLY_ABORT_EN, finish rises at edge 11 instead of 66.
- Assert rst_b low at cycle 20 of COMPUTE:
  - finish=0, sigvalid=0 immediately.
  - after release and a new start edge, a full run completes with correct result.
- From DONE, drop start, raise again:
  - finish and sigvalid clear on the trigger edge.
  - a new result appears 66 edges later.
